// File: rtl/uart_image_rx_ctrl_if.sv
// Byte stream from the UART receiver and the pixel write port into the image buffer.
// The controller takes the slave view; the receiver/buffer side takes the master view.
interface uart_image_rx_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output rx_data,
        output rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/uart_image_rx_ctrl.sv
// Frame parser for the image transfer protocol: SYNC, WIDTH, HEIGHT, W*H pixels, CHECKSUM.
// Writes pixels to the image buffer and reports completion, checksum and error status.
module uart_image_rx_ctrl #(
    parameter int unsigned ADDR_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    uart_image_rx_ctrl_if.slave bus,
    output logic [7:0]          img_width,
    output logic [7:0]          img_height,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_ok,
    output logic                err_checksum,
    output logic                err_timeout,
    output logic                err_size
);
    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_PIX = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_W  = 3'd1,
        ST_HDR_H  = 3'd2,
        ST_PIXELS = 3'd3,
        ST_CHKSUM = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_nxt_s;
    logic [7:0]        width_r, width_nxt_s;
    logic [7:0]        height_r, height_nxt_s;
    logic [15:0]       total_r, total_nxt_s;
    logic [15:0]       pix_cnt_r, pix_cnt_nxt_s;
    logic [7:0]        sum_r, sum_nxt_s;
    logic              wr_en_r, wr_en_nxt_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
    logic [7:0]        wr_data_r, wr_data_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              frame_done_r, frame_done_nxt_s;
    logic              frame_ok_r, frame_ok_nxt_s;
    logic              err_checksum_r, err_checksum_nxt_s;
    logic              err_timeout_r, err_timeout_nxt_s;
    logic              err_size_r, err_size_nxt_s;
    logic [15:0]       area_s;

    // Next-state, datapath and registered-output decode for each cycle
    always_comb begin
        state_nxt_s        = state_r;
        to_cnt_nxt_s       = {TO_W{1'b0}};
        width_nxt_s        = width_r;
        height_nxt_s       = height_r;
        total_nxt_s        = total_r;
        pix_cnt_nxt_s      = pix_cnt_r;
        sum_nxt_s          = sum_r;
        wr_en_nxt_s        = 1'b0;
        wr_addr_nxt_s      = wr_addr_r;
        wr_data_nxt_s      = wr_data_r;
        frame_done_nxt_s   = 1'b0;
        frame_ok_nxt_s     = frame_ok_r;
        err_checksum_nxt_s = err_checksum_r;
        err_timeout_nxt_s  = err_timeout_r;
        err_size_nxt_s     = err_size_r;
        area_s             = {8'h00, width_r} * {8'h00, bus.rx_data};

        if (state_r == ST_IDLE) begin
            if (enable && bus.rx_ready && (bus.rx_data == SYNC_BYTE)) begin
                state_nxt_s        = ST_HDR_W;
                frame_ok_nxt_s     = 1'b0;
                err_checksum_nxt_s = 1'b0;
                err_timeout_nxt_s  = 1'b0;
                err_size_nxt_s     = 1'b0;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else if (!bus.rx_ready) begin
            // A byte in the expiry cycle takes the branch below, so it always wins
            if (to_cnt_r == TO_LAST) begin
                state_nxt_s       = ST_IDLE;
                err_timeout_nxt_s = 1'b1;
            end else begin
                to_cnt_nxt_s = to_cnt_r + TO_W'(1'b1);
            end
        end else begin
            case (state_r)
                ST_HDR_W: begin
                    width_nxt_s = bus.rx_data;
                    state_nxt_s = ST_HDR_H;
                end
                ST_HDR_H: begin
                    height_nxt_s  = bus.rx_data;
                    total_nxt_s   = area_s;
                    pix_cnt_nxt_s = 16'h0000;
                    sum_nxt_s     = 8'h00;
                    if ((width_r == 8'h00) || (bus.rx_data == 8'h00) ||
                        ({1'b0, area_s} > MAX_PIX)) begin
                        err_size_nxt_s = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PIXELS;
                    end
                end
                ST_PIXELS: begin
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = pix_cnt_r[ADDR_W-1:0];
                    wr_data_nxt_s = bus.rx_data;
                    sum_nxt_s     = sum_r + bus.rx_data;
                    pix_cnt_nxt_s = pix_cnt_r + 16'd1;
                    if (pix_cnt_r == (total_r - 16'd1)) begin
                        state_nxt_s = ST_CHKSUM;
                    end else begin
                        state_nxt_s = ST_PIXELS;
                    end
                end
                ST_CHKSUM: begin
                    frame_done_nxt_s   = 1'b1;
                    frame_ok_nxt_s     = (bus.rx_data == sum_r);
                    err_checksum_nxt_s = (bus.rx_data != sum_r);
                    state_nxt_s        = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, frame bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r       <= {TO_W{1'b0}};
            width_r        <= 8'h00;
            height_r       <= 8'h00;
            total_r        <= 16'h0000;
            pix_cnt_r      <= 16'h0000;
            sum_r          <= 8'h00;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= {ADDR_W{1'b0}};
            wr_data_r      <= 8'h00;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
            frame_ok_r     <= 1'b0;
            err_checksum_r <= 1'b0;
            err_timeout_r  <= 1'b0;
            err_size_r     <= 1'b0;
        end else begin
            to_cnt_r       <= to_cnt_nxt_s;
            width_r        <= width_nxt_s;
            height_r       <= height_nxt_s;
            total_r        <= total_nxt_s;
            pix_cnt_r      <= pix_cnt_nxt_s;
            sum_r          <= sum_nxt_s;
            wr_en_r        <= wr_en_nxt_s;
            wr_addr_r      <= wr_addr_nxt_s;
            wr_data_r      <= wr_data_nxt_s;
            busy_r         <= busy_nxt_s;
            frame_done_r   <= frame_done_nxt_s;
            frame_ok_r     <= frame_ok_nxt_s;
            err_checksum_r <= err_checksum_nxt_s;
            err_timeout_r  <= err_timeout_nxt_s;
            err_size_r     <= err_size_nxt_s;
        end
    end

    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign img_width    = width_r;
    assign img_height   = height_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;
    assign frame_ok     = frame_ok_r;
    assign err_checksum = err_checksum_r;
    assign err_timeout  = err_timeout_r;
    assign err_size     = err_size_r;
endmodule

// File: tb/tb_uart_image_rx_ctrl.sv
// Bench for uart_image_rx_ctrl: cycle-accurate vector table, directed corner sequences,
// and randomized frames checked against a frame-level model of the protocol.
`timescale 1ns/1ps
module tb_uart_image_rx_ctrl;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned TO     = 50;
    localparam logic [7:0]  SYNC   = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] img_width, img_height;
    logic       busy, frame_done, frame_ok, err_checksum, err_timeout, err_size;

    uart_image_rx_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_image_rx_ctrl #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bus          (bus),
        .img_width    (img_width),
        .img_height   (img_height),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .err_size     (err_size)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [ADDR_W+7:0] wr_q[$];

    // Write and frame_done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
        if (frame_done) done_cnt++;
    end

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       x_wr;
        logic [7:0] x_addr;
        logic [7:0] x_data;
        logic       x_busy;
        logic       x_done;
        logic [3:0] x_flags;  // {frame_ok, err_checksum, err_timeout, err_size}
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rdy, input logic [7:0] data, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       input logic bsy, input logic done, input logic [3:0] flags);
        vec_t v;
        v.rdy = rdy; v.data = data; v.x_wr = wr; v.x_addr = addr; v.x_data = wdata;
        v.x_busy = bsy; v.x_done = done; v.x_flags = flags;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick(input logic rdy, input logic [7:0] d);
        bus.rx_ready = rdy;
        bus.rx_data  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic gap(input int mx);
        idle(int'($urandom_range(mx)));
    endtask

    // Sends one frame and checks it against what the protocol rules predict
    task automatic run_frame(input string name, input logic [7:0] w, input logic [7:0] h,
                             input bit bad_chk, input int gap_max);
        logic [7:0] pix[$];
        logic [7:0] sum;
        logic [7:0] b;
        int total, base, done0, nbad;
        bit size_bad, exp_ok;
        total    = int'(w) * int'(h);
        size_bad = (w == 8'h00) || (h == 8'h00) || (total > (1 << ADDR_W));
        base     = wr_q.size();
        done0    = done_cnt;
        sum      = 8'h00;
        send(SYNC); gap(gap_max);
        send(w);    gap(gap_max);
        send(h);
        if (!size_bad) begin
            for (int i = 0; i < total; i++) begin
                gap(gap_max);
                b = ($urandom_range(3) == 0) ? SYNC : 8'($urandom);
                pix.push_back(b);
                sum = sum + b;
                send(b);
            end
            gap(gap_max);
            send(bad_chk ? sum + 8'($urandom_range(255, 1)) : sum);
        end
        tick(1'b0, 8'h00);
        exp_ok = !size_bad && !bad_chk;
        check({name, " writes"}, 64'(wr_q.size() - base), size_bad ? 64'd0 : 64'(total));
        if (!size_bad) begin
            nbad = 0;
            for (int i = 0; i < pix.size() && base + i < wr_q.size(); i++)
                if (wr_q[base+i] !== {ADDR_W'(i), pix[i]}) nbad++;
            check({name, " wdata"}, 64'(nbad), 64'd0);
        end
        check({name, " done"}, 64'(done_cnt - done0), size_bad ? 64'd0 : 64'd1);
        check({name, " flags"},
              64'({busy, frame_ok, err_checksum, err_timeout, err_size}),
              64'({1'b0, exp_ok, !size_bad && bad_chk, 1'b0, size_bad}));
    endtask

    initial begin
        logic [63:0] got, exp;
        int base, done0;

        // 2x2 frame, good checksum, with one idle cycle between pixels
        add(1, 8'hA5, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h10, 1, 0, 8'h10, 1, 0, 4'b0000);
        add(0, 8'h00, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h20, 1, 1, 8'h20, 1, 0, 4'b0000);
        add(1, 8'h30, 1, 2, 8'h30, 1, 0, 4'b0000);
        add(1, 8'h40, 1, 3, 8'h40, 1, 0, 4'b0000);
        add(1, 8'hA0, 0, 0, 0, 0, 1, 4'b1000);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b1000);
        // same frame, bad checksum
        add(1, 8'hA5, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h10, 1, 0, 8'h10, 1, 0, 4'b0000);
        add(1, 8'h20, 1, 1, 8'h20, 1, 0, 4'b0000);
        add(1, 8'h30, 1, 2, 8'h30, 1, 0, 4'b0000);
        add(1, 8'h40, 1, 3, 8'h40, 1, 0, 4'b0000);
        add(1, 8'h00, 0, 0, 0, 0, 1, 4'b0100);
        // garbage, then zero width
        add(1, 8'h33, 0, 0, 0, 0, 0, 4'b0100);
        add(1, 8'hA5, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h00, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h05, 0, 0, 0, 0, 0, 4'b0001);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b0001);
        // 1x2 frame whose pixels equal the sync value
        add(1, 8'hA5, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h01, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 4'b0000);
        add(1, 8'hA5, 1, 0, 8'hA5, 1, 0, 4'b0000);
        add(1, 8'hA5, 1, 1, 8'hA5, 1, 0, 4'b0000);
        add(1, 8'h4A, 0, 0, 0, 0, 1, 4'b1000);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b1000);

        reset_n = 1'b0;
        enable  = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        check("reset", 64'({bus.wr_en, bus.wr_addr, bus.wr_data, img_width, img_height, busy,
                            frame_done, frame_ok, err_checksum, err_timeout, err_size}), 64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        idle(1);

        foreach (tbl[i]) begin
            tick(tbl[i].rdy, tbl[i].data);
            got = 64'({bus.wr_en, bus.wr_en ? 8'(bus.wr_addr) : 8'h00,
                       bus.wr_en ? bus.wr_data : 8'h00, busy, frame_done,
                       frame_ok, err_checksum, err_timeout, err_size});
            exp = 64'({tbl[i].x_wr, tbl[i].x_wr ? tbl[i].x_addr : 8'h00,
                       tbl[i].x_wr ? tbl[i].x_data : 8'h00, tbl[i].x_busy,
                       tbl[i].x_done, tbl[i].x_flags});
            check($sformatf("vec%0d", i), got, exp);
        end
        check("dims", 64'({img_width, img_height}), 64'h0102);

        // silence for the full timeout window
        done0 = done_cnt;
        send(SYNC); send(8'h01); send(8'h03); send(8'h11);
        idle(TO - 1);
        check("to_pre", 64'({busy, err_timeout}), 64'h2);
        idle(1);
        check("to_fire", 64'({busy, frame_done, frame_ok, err_checksum, err_timeout, err_size}),
              64'h02);
        check("to_nodone", 64'(done_cnt - done0), 64'd0);

        // byte arriving in the expiry cycle keeps the frame alive
        send(SYNC); send(8'h01); send(8'h03); send(8'h11);
        idle(TO - 1);
        send(8'h22);
        check("edge_wr", 64'({busy, err_timeout, bus.wr_en, bus.wr_addr, bus.wr_data}),
              64'({1'b1, 1'b0, 1'b1, 6'd1, 8'h22}));
        idle(TO - 1); send(8'h33);
        idle(TO - 1); send(8'h66);
        check("edge_done", 64'({busy, frame_done, frame_ok, err_checksum, err_timeout}),
              64'b01100);

        // frame-size boundaries
        run_frame("max64", 8'd8, 8'd8, 1'b0, 0);
        run_frame("over65", 8'd13, 8'd5, 1'b0, 0);

        // enable dropped mid-frame
        base  = wr_q.size();
        done0 = done_cnt;
        send(SYNC); send(8'h02); send(8'h02); send(8'h10); send(8'h20);
        enable = 1'b0;
        tick(1'b0, 8'h00);
        check("endrop_state", 64'({busy, frame_ok, err_checksum, err_timeout, err_size}), 64'd0);
        send(8'h30); send(8'h40); send(SYNC);
        tick(1'b0, 8'h00);
        check("endrop_writes", 64'(wr_q.size() - base), 64'd2);
        check("endrop_idle", 64'({busy, 32'(done_cnt - done0)}), 64'd0);
        enable = 1'b1;
        run_frame("after_drop", 8'd2, 8'd2, 1'b0, 1);

        // asynchronous reset while a write is pending
        send(SYNC); send(8'h02); send(8'h02); send(8'h10);
        check("rst_pre_wr", 64'(bus.wr_en), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async", 64'({bus.wr_en, bus.wr_addr, bus.wr_data, img_width, img_height, busy,
                                frame_done, frame_ok, err_checksum, err_timeout, err_size}), 64'd0);
        idle(2);
        reset_n = 1'b1;
        run_frame("after_rst", 8'd2, 8'd2, 1'b0, 2);

        // randomized frames with leading garbage and random gaps
        for (int k = 0; k < 25; k++) begin
            logic [7:0] g;
            repeat ($urandom_range(2)) begin
                g = 8'($urandom);
                send((g == SYNC) ? 8'h00 : g);
            end
            run_frame($sformatf("rand%0d", k), 8'($urandom_range(9)), 8'($urandom_range(9)),
                      1'($urandom_range(1)), 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
